// File: rtl/mac_ctrl_pkg.sv
// Shared types and helpers for the MAC timestep controller.
package mac_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONFIG = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_CLEAR  = 2'd3
  } state_e;

  localparam int unsigned MAC_ADDR_W = 12;

  // Bits needed to count 0..max_val-1 (minimum one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr wins; next pointer is winner+1.
module rr_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned PTR_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] gnt_c,
  output logic [PTR_W-1:0]     ptr_nxt_c,
  output logic                 hit_c
);

  int unsigned idx;

  always_comb begin
    gnt_c     = '0;
    ptr_nxt_c = ptr;
    hit_c     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!hit_c && req[PTR_W'(idx)]) begin
        hit_c              = 1'b1;
        gnt_c[PTR_W'(idx)] = 1'b1;
        ptr_nxt_c          = (idx == NUM_PORTS - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

endmodule

// File: rtl/mac_timestep_controller.sv
// Sequences a neuron MAC through config and fixed-length timesteps, and
// round-robin funnels spike addresses from several ports onto the MAC input.
module mac_timestep_controller
  import mac_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned ADDR_W     = MAC_ADDR_W,
  parameter int unsigned TS_CYCLES  = 4,
  parameter int unsigned CFG_CYCLES = 2,
  parameter int unsigned TS_IDX_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        stop,
  input  logic [NUM_PORTS-1:0]        spike_valid,
  input  logic [NUM_PORTS*ADDR_W-1:0] spike_addr,
  output logic [NUM_PORTS-1:0]        spike_ready,
  output logic [ADDR_W-1:0]           mac_source_addr,
  output logic                        mac_addr_strobe,
  output logic                        mac_set,
  output logic                        mac_clear,
  output logic                        ts_done,
  output logic [TS_IDX_W-1:0]         ts_index,
  output logic                        busy
);

  localparam int unsigned CNT_MAX = (CFG_CYCLES > TS_CYCLES) ? CFG_CYCLES : TS_CYCLES;
  localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
  localparam int unsigned PTR_W   = cnt_width(NUM_PORTS);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  stop_pend_q, stop_pend_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  strobe_q, strobe_d;
  logic [TS_IDX_W-1:0]   ts_index_q, ts_index_d;
  logic                  mac_set_q, mac_set_d;
  logic                  mac_clear_q, mac_clear_d;
  logic                  ts_done_q, ts_done_d;
  logic                  busy_q, busy_d;

  logic                  grant_en;
  logic [ADDR_W-1:0]     sel_addr;
  logic [NUM_PORTS-1:0]  gnt_c;
  logic [PTR_W-1:0]      ptr_nxt_c;
  logic                  hit_c;
  logic [ADDR_W-1:0]     addr_arr [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign addr_arr[g] = spike_addr[g*ADDR_W +: ADDR_W];
  end

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_arb (
    .req       (spike_valid),
    .ptr       (ptr_q),
    .gnt_c     (gnt_c),
    .ptr_nxt_c (ptr_nxt_c),
    .hit_c     (hit_c)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;
    ptr_d       = ptr_q;
    addr_d      = addr_q;
    strobe_d    = 1'b0;
    ts_index_d  = ts_index_q;
    grant_en    = 1'b0;
    spike_ready = '0;
    sel_addr    = '0;

    case (state_q)
      ST_IDLE: begin
        // stop arriving with start is kept so exactly one timestep runs
        if (start) begin
          state_d     = ST_CONFIG;
          cnt_d       = '0;
          stop_pend_d = stop;
        end
      end
      ST_CONFIG: begin
        stop_pend_d = stop_pend_q | stop;
        if (cnt_q == CNT_W'(CFG_CYCLES - 1)) begin
          state_d = ST_ACCUM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACCUM: begin
        // final ACCUM cycle is a guard so no address lands during CLEAR
        stop_pend_d = stop_pend_q | stop;
        grant_en    = (cnt_q < CNT_W'(TS_CYCLES - 2));
        if (cnt_q == CNT_W'(TS_CYCLES - 2)) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CLEAR: begin
        cnt_d       = '0;
        stop_pend_d = 1'b0;
        state_d     = (stop_pend_q | stop) ? ST_IDLE : ST_ACCUM;
      end
      default: state_d = ST_IDLE;
    endcase

    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (gnt_c[PTR_W'(i)]) sel_addr = addr_arr[PTR_W'(i)];
    end

    if (grant_en) begin
      spike_ready = gnt_c;
      if (hit_c) begin
        strobe_d = 1'b1;
        addr_d   = sel_addr;
        ptr_d    = ptr_nxt_c;
      end
    end

    if (state_d == ST_CLEAR) ts_index_d = ts_index_q + TS_IDX_W'(1);

    mac_set_d   = (state_d == ST_CONFIG);
    mac_clear_d = (state_d == ST_CLEAR);
    ts_done_d   = (state_d == ST_CLEAR);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
      ptr_q       <= '0;
      addr_q      <= '0;
      strobe_q    <= 1'b0;
      ts_index_q  <= '0;
      mac_set_q   <= 1'b0;
      mac_clear_q <= 1'b0;
      ts_done_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      strobe_q    <= strobe_d;
      ts_index_q  <= ts_index_d;
      mac_set_q   <= mac_set_d;
      mac_clear_q <= mac_clear_d;
      ts_done_q   <= ts_done_d;
      busy_q      <= busy_d;
    end
  end

  assign mac_source_addr = addr_q;
  assign mac_addr_strobe = strobe_q;
  assign mac_set         = mac_set_q;
  assign mac_clear       = mac_clear_q;
  assign ts_done         = ts_done_q;
  assign ts_index        = ts_index_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_mac_timestep_controller.sv
// Scoreboard bench for mac_timestep_controller with a timeline-based reference model.
module tb_mac_timestep_controller;

  localparam int unsigned NP  = 4;
  localparam int unsigned AW  = 12;
  localparam int unsigned TS  = 4;
  localparam int unsigned CFG = 2;
  localparam int unsigned TW  = 16;

  localparam int PH_IDLE  = 0;
  localparam int PH_CFG   = 1;
  localparam int PH_GRANT = 2;
  localparam int PH_GUARD = 3;
  localparam int PH_CLR   = 4;

  typedef struct packed {
    logic [4:0]    ctl;   // {set, clear, done, busy, strobe}
    logic [TW-1:0] ts;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              stop;
  logic [NP-1:0]     spike_valid;
  logic [NP*AW-1:0]  spike_addr;
  logic [NP-1:0]     spike_ready;
  logic [AW-1:0]     mac_source_addr;
  logic              mac_addr_strobe;
  logic              mac_set;
  logic              mac_clear;
  logic              ts_done;
  logic [TW-1:0]     ts_index;
  logic              busy;

  mac_timestep_controller #(
    .NUM_PORTS  (NP),
    .ADDR_W     (AW),
    .TS_CYCLES  (TS),
    .CFG_CYCLES (CFG),
    .TS_IDX_W   (TW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .stop            (stop),
    .spike_valid     (spike_valid),
    .spike_addr      (spike_addr),
    .spike_ready     (spike_ready),
    .mac_source_addr (mac_source_addr),
    .mac_addr_strobe (mac_addr_strobe),
    .mac_set         (mac_set),
    .mac_clear       (mac_clear),
    .ts_done         (ts_done),
    .ts_index        (ts_index),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  exp_t          exp_q [$];
  logic [AW-1:0] addr_q[$];
  logic [TW-1:0] ts_q  [$];
  int            fair_q[$];
  bit            mon_en = 1'b0;

  // reference model: position on a timeline measured from the last start
  bit            m_run;
  int            m_s;
  bit            m_pend;
  int            m_ptr;
  logic [TW-1:0] m_ts;

  // requesters
  logic [NP-1:0] pend;
  logic [AW-1:0] paddr [NP];
  logic [AW-1:0] fix_addr [NP];
  int            mode;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s t=%0t", nm, $time);
  endtask

  function automatic int ph();
    int off;
    if (!m_run) return PH_IDLE;
    if (m_s < int'(CFG)) return PH_CFG;
    off = (m_s - int'(CFG)) % int'(TS);
    if (off == int'(TS) - 1) return PH_CLR;
    if (off == int'(TS) - 2) return PH_GUARD;
    return PH_GRANT;
  endfunction

  // One cycle: drive inputs at negedge, check spike_ready, advance model, queue expectations.
  task automatic step(input logic st, input logic sp, input logic rn);
    logic [NP-1:0] exp_rdy;
    int            g;
    int            cur;
    int            nxt;
    bit            xfer;
    exp_t          e;
    @(negedge clk);
    rst_n = rn;
    start = st;
    stop  = sp;
    cur   = ph();
    for (int i = 0; i < int'(NP); i++) begin
      if (!pend[i]) begin
        case (mode)
          1: begin pend[i] = 1'b1; paddr[i] = fix_addr[i]; end
          2: if ($urandom_range(2) == 0) begin pend[i] = 1'b1; paddr[i] = AW'($urandom); end
          3: if (i == 2 && cur == PH_GUARD) begin pend[i] = 1'b1; paddr[i] = AW'(2); end
          default: ;
        endcase
      end
      spike_valid[i]        = pend[i];
      spike_addr[i*AW +: AW] = paddr[i];
    end
    #1;
    if (!rn) begin
      chk("rst_ctl", 32'({spike_ready, mac_set, mac_clear, ts_done, busy, mac_addr_strobe}), 32'd0);
      chk("rst_addr", 32'(mac_source_addr), 32'd0);
      chk("rst_ts", 32'(ts_index), 32'd0);
      m_run = 1'b0; m_s = 0; m_pend = 1'b0; m_ptr = 0; m_ts = '0;
      exp_q.delete(); addr_q.delete(); ts_q.delete();
      e = '0;
      exp_q.push_back(e);
      mon_en = 1'b1;
      return;
    end
    exp_rdy = '0;
    xfer    = 1'b0;
    g       = -1;
    if (cur == PH_GRANT) begin
      for (int k = 0; k < int'(NP); k++) begin
        if (g < 0 && pend[(m_ptr + k) % int'(NP)]) g = (m_ptr + k) % int'(NP);
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("spike_ready", 32'(spike_ready), 32'(exp_rdy));
    if (mode == 1) begin
      for (int i = 0; i < int'(NP); i++) if (spike_ready[i]) fair_q.push_back(i);
    end
    if (g >= 0) begin
      xfer = 1'b1;
      addr_q.push_back(paddr[g]);
      pend[g] = 1'b0;
      m_ptr   = (g + 1) % int'(NP);
    end
    if (!m_run) begin
      if (st) begin m_run = 1'b1; m_s = 0; m_pend = sp; end
    end else begin
      m_pend = m_pend | sp;
      if (cur == PH_CLR && m_pend) begin
        m_run = 1'b0; m_pend = 1'b0;
      end else begin
        if (cur == PH_CLR) m_pend = 1'b0;
        m_s++;
      end
    end
    nxt = ph();
    if (nxt == PH_CLR) begin
      m_ts = m_ts + TW'(1);
      ts_q.push_back(m_ts);
    end
    e.ctl = {nxt == PH_CFG, nxt == PH_CLR, nxt == PH_CLR, m_run, xfer};
    e.ts  = m_ts;
    exp_q.push_back(e);
    mon_en = 1'b1;
  endtask

  task automatic run_until(input int target, input int maxc, input string nm);
    int n = 0;
    while (ph() != target && n < maxc) begin
      step(1'b0, 1'b0, 1'b1);
      n++;
    end
    if (ph() != target) fail(nm);
  endtask

  task automatic do_reset();
    pend = '0;
    mode = 0;
    repeat (2) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
  endtask

  // monitor: pops one expectation per cycle, and address/index entries on strobes
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) begin
        if (mon_en) fail("sb_underflow");
      end else begin
        e = exp_q.pop_front();
        chk("ctrl", 32'({mac_set, mac_clear, ts_done, busy, mac_addr_strobe}), 32'(e.ctl));
        chk("ts_index", 32'(ts_index), 32'(e.ts));
        if (mac_addr_strobe) begin
          if (addr_q.size() == 0) fail("addr_underflow");
          else chk("src_addr", 32'(mac_source_addr), 32'(addr_q.pop_front()));
        end
        if (ts_done) begin
          if (ts_q.size() == 0) fail("ts_underflow");
          else chk("done_index", 32'(ts_index), 32'(ts_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int exp_fair [6];
    exp_fair = '{0, 1, 2, 3, 0, 1};
    fix_addr = '{AW'(0), AW'(1), AW'(2), AW'(7)};
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    spike_valid = '0; spike_addr = '0;
    pend = '0; mode = 0;
    for (int i = 0; i < int'(NP); i++) paddr[i] = '0;
    m_run = 1'b0; m_s = 0; m_pend = 1'b0; m_ptr = 0; m_ts = '0;

    // reset then idle
    repeat (3) step(1'b0, 1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b1);

    // config and timestep cadence without spikes
    step(1'b1, 1'b0, 1'b1);
    repeat (CFG + 3 * TS) step(1'b0, 1'b0, 1'b1);

    // stop mid-accumulate, then restart with ts_index continuing
    run_until(PH_GRANT, 2 * TS, "wait_grant");
    step(1'b0, 1'b1, 1'b1);
    run_until(PH_IDLE, 2 * TS, "stop_timeout");
    repeat (3) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    repeat (CFG + TS + 1) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    run_until(PH_IDLE, 2 * TS, "stop2_timeout");

    // fairness with all ports requesting continuously
    do_reset();
    mode = 1;
    step(1'b1, 1'b0, 1'b1);
    repeat (CFG + 3 * TS) step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (i < fair_q.size()) chk("fair_order", 32'(fair_q[i]), 32'(exp_fair[i]));
      else fail("fair_short");
    end
    mode = 0;
    step(1'b0, 1'b1, 1'b1);
    run_until(PH_IDLE, 2 * TS, "fair_stop_timeout");

    // request arriving in the guard cycle is held into the next timestep
    do_reset();
    mode = 3;
    step(1'b1, 1'b0, 1'b1);
    repeat (CFG + 4 * TS) step(1'b0, 1'b0, 1'b1);
    mode = 0;

    // start and stop together: exactly one timestep
    do_reset();
    step(1'b1, 1'b1, 1'b1);
    run_until(PH_IDLE, CFG + TS + 2, "one_ts_timeout");
    repeat (3) step(1'b0, 1'b0, 1'b1);

    // asynchronous reset while a strobe is out and a request is pending
    do_reset();
    mode = 1;
    step(1'b1, 1'b0, 1'b1);
    run_until(PH_GRANT, CFG + 2, "wait_grant2");
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    mode = 0;
    repeat (6) step(1'b0, 1'b0, 1'b1);

    // randomized traffic and control
    do_reset();
    mode = 2;
    repeat (600) begin
      step(1'($urandom_range(7) == 0), 1'($urandom_range(29) == 0), 1'($urandom_range(199) != 0));
    end
    mode = 0;
    step(1'b0, 1'b1, 1'b1);
    run_until(PH_IDLE, 2 * TS + CFG, "final_stop_timeout");
    repeat (3) step(1'b0, 1'b0, 1'b1);

    @(posedge clk);
    #3;
    chk("addr_q_left", 32'(addr_q.size()), 32'd0);
    chk("ts_q_left", 32'(ts_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
